// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// using a single full-subtractor cell with a start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             load_s;
  logic             shift_s;
  logic             last_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             br_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             busy_r;
  logic             done_r;
  logic             d_s;
  logic             br_next_s;

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fs_cell(input logic ai, input logic bi, input logic br);
    logic [1:0] r;
    r[0] = ai ^ bi ^ br;
    r[1] = (~ai & bi) | (~(ai ^ bi) & br);
    return r;
  endfunction

  // Current bit of the subtraction from the low bits of the operand shifters.
  always_comb begin
    {br_next_s, d_s} = fs_cell(a_r[0], b_r[0], br_r);
  end

  // Next-state and datapath control decode.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s       = 1'b1;
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        shift_s = 1'b1;
        if (count_r == CW'(WIDTH - 1)) begin
          last_s       = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = SHIFT;
        end
      end
      DONE: begin
        // Start during DONE chains straight into the next operation.
        if (start) begin
          load_s       = 1'b1;
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand capture, bit-serial shifting and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      br_r    <= 1'b0;
      count_r <= {CW{1'b0}};
      diff_r  <= {WIDTH{1'b0}};
      bout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= (next_state_s == SHIFT);
      done_r <= last_s;
      if (load_s) begin
        a_r     <= a;
        b_r     <= b;
        br_r    <= bin;
        res_r   <= {WIDTH{1'b0}};
        count_r <= {CW{1'b0}};
      end else if (shift_s) begin
        a_r     <= {1'b0, a_r[WIDTH-1:1]};
        b_r     <= {1'b0, b_r[WIDTH-1:1]};
        res_r   <= {d_s, res_r[WIDTH-1:1]};
        br_r    <= br_next_s;
        count_r <= count_r + CW'(1);
        if (last_s) begin
          diff_r <= {d_s, res_r[WIDTH-1:1]};
          bout_r <= br_next_s;
        end
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed cases,
// randomized operations and an exhaustive sweep against an arithmetic model.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int compared;
  int mismatched;

  logic [WIDTH:0] exp_res;
  logic [WIDTH:0] held_res;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    if (obs !== expv) begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    if (r < 0) r = r + (1 << (WIDTH + 1));
    return (WIDTH + 1)'(r);
  endfunction

  // Present operands with start at a negedge; the following posedge accepts them.
  task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    start   = 1'b1;
    a       = x;
    b       = y;
    bin     = c;
    exp_res = ref_sub(x, y, c);
    @(negedge clk);
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    bin   = 1'($urandom);
  endtask

  // Follow one operation from its first busy cycle through the done pulse.
  task automatic track(input bit noise, input bit chain,
                       input logic [WIDTH-1:0] cx, input logic [WIDTH-1:0] cy, input logic cc);
    for (int i = 0; i < WIDTH; i++) begin
      check_val("busy_high", 32'(busy), 32'd1);
      check_val("done_low_busy", 32'(done), 32'd0);
      check_val("hold_busy", 32'({bout, diff}), 32'(held_res));
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        bin   = 1'($urandom);
      end
      @(negedge clk);
    end
    check_val("done_pulse", 32'(done), 32'd1);
    check_val("busy_low_done", 32'(busy), 32'd0);
    check_val("result", 32'({bout, diff}), 32'(exp_res));
    held_res = exp_res;
    if (chain) begin
      launch(cx, cy, cc);
    end else begin
      start = 1'b0;
      @(negedge clk);
      check_val("done_one_cycle", 32'(done), 32'd0);
      check_val("hold_idle", 32'({bout, diff}), 32'(held_res));
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    held_res   = '0;
    exp_res    = '0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_result", 32'({bout, diff}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    launch(4'b0111, 4'b0011, 1'b0);
    track(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    check_val("t1_diff", 32'(diff), 32'b0100);
    launch(4'b0011, 4'b0101, 1'b0);
    track(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    check_val("t2a_val", 32'({bout, diff}), 32'b11110);
    launch(4'b0000, 4'b0000, 1'b1);
    track(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    check_val("t2b_val", 32'({bout, diff}), 32'b11111);

    // Start re-pulsed mid-operation with a=1111 must be ignored
    launch(4'b1011, 4'b0111, 1'b1);
    start = 1'b1;
    a     = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < WIDTH; i++) begin
      check_val("t3_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check_val("t3_done", 32'(done), 32'd1);
    check_val("t3_val", 32'({bout, diff}), 32'b00011);
    held_res = 5'b00011;
    @(negedge clk);
    check_val("t3_no_rerun", 32'(busy), 32'd0);

    // Back-to-back: second done exactly WIDTH+1 cycles after the first
    launch(4'b1001, 4'b0010, 1'b0);
    track(1'b0, 1'b1, 4'b0101, 4'b0001, 1'b0);
    track(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    check_val("t4_diff", 32'(diff), 32'b0100);

    // Reset in the middle of an operation
    launch(4'b1100, 4'b0011, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("t5_busy", 32'(busy), 32'd0);
    check_val("t5_done", 32'(done), 32'd0);
    check_val("t5_result", 32'({bout, diff}), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    held_res = '0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      check_val("t5_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    launch(4'b1100, 4'b0011, 1'b0);
    track(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

    // Randomized operations with input noise during SHIFT, some chained
    for (int n = 0; n < 60; n++) begin
      logic [WIDTH-1:0] rx;
      logic [WIDTH-1:0] ry;
      logic             rc;
      rx = WIDTH'($urandom);
      ry = WIDTH'($urandom);
      rc = 1'($urandom);
      launch(rx, ry, rc);
      track(1'b1, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      track(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    end

    // Exhaustive sweep
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          launch(WIDTH'(x), WIDTH'(y), 1'(c));
          track(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
